// File: rtl/mitm_pkg.sv
// Shared definitions for the MITM bus controller.
// State encodings, edge selection and derived widths.
package mitm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_START    = 3'd1;
  localparam state_t ST_EVAL_REQ = 3'd2;
  localparam state_t ST_EVAL     = 3'd3;
  localparam state_t ST_LOAD     = 3'd4;
  localparam state_t ST_SEG      = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

  function automatic bit sample_on_rise(
    input bit cpol,
    input bit cpha
  );
    return cpol == cpha;
  endfunction

  function automatic int dsw_of(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

endpackage

// File: rtl/mitm_control_multi_lane_shifter.sv
// One lane: capture shift register, committed capture,
// and MSB-first replacement bit register.
module lane_shifter
  import mitm_pkg::*;
#(
  parameter int MAX = 9,
  parameter int DSW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           latch_i,
  input  logic [MAX-1:0] fake_i,
  input  logic           load_i,
  input  logic           drive_i,
  input  logic           sample_i,
  input  logic           commit_i,
  input  logic           shift_i,
  input  logic           bit_i,
  input  logic [DSW-1:0] n_i,
  output logic           fake_bit_o,
  output logic [MAX-1:0] real_o
);

  logic [MAX-1:0] fq_q;
  logic [MAX-1:0] cap_q;
  logic [MAX-1:0] real_q;
  logic           bit_q;
  logic [MAX-1:0] cap_d;
  logic [DSW-1:0] idx;
  logic           present;

  assign cap_d   = {cap_q[MAX-2:0], bit_i};
  assign idx     = n_i - DSW'(1);
  assign present = (load_i && drive_i) || shift_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq_q   <= '0;
      cap_q  <= '0;
      real_q <= '0;
      bit_q  <= 1'b0;
    end else begin
      if (latch_i) fq_q <= fake_i;
      if (load_i) cap_q <= '0;
      // fq_q slides left so bit n-1 is always the next one out
      if (present) begin
        bit_q <= fq_q[idx];
        fq_q  <= fq_q << 1;
      end
      if (sample_i) cap_q <= cap_d;
      if (commit_i) real_q <= cap_d;
    end
  end

  assign fake_bit_o = bit_q;
  assign real_o     = real_q;

endmodule

// File: rtl/mitm_control_multi.sv
// MITM controller for multi-lane SPI-style links:
// sync, edge detect, segment FSM and output mux.
module mitm_control_multi
  import mitm_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int MAX_DATA_SIZE = 9,
  parameter bit CPOL          = 1'b0,
  parameter bit CPHA          = 1'b0,
  parameter bit SS_ACTIVE     = 1'b1,
  parameter int SYNC_STAGES   = 2,
  parameter int SEG_CNT_W     = 8,
  parameter int DSW           = dsw_of(MAX_DATA_SIZE)
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           sclk_in,
  input  logic                           ss_in,
  input  logic [LANES-1:0]               lane_in,
  output logic                           sclk_out,
  output logic                           ss_out,
  output logic [LANES-1:0]               lane_out,
  output logic                           mitm_start,
  output logic                           mitm_eval,
  input  logic                           eval_done,
  input  logic                           mitm_done,
  input  logic [DSW-1:0]                 data_size,
  input  logic [LANES*MAX_DATA_SIZE-1:0] fake_data,
  input  logic [LANES-1:0]               fake_select,
  output logic [LANES*MAX_DATA_SIZE-1:0] real_data,
  output logic [SEG_CNT_W-1:0]           seg_count,
  output logic                           busy,
  output logic                           abort
);

  localparam int SW = LANES + 2;
  localparam bit SMP_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic [SW-1:0] SYNC_RST =
    {{LANES{1'b0}}, ~SS_ACTIVE, CPOL};

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [1:0]                     hist_q;
  logic [SW-1:0]                  s_now;
  logic [LANES-1:0]               lane_s;
  logic rise, fall, smp_edge, shf_edge;
  logic ss_act, ss_act_h, ss_on, ss_off;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
      hist_q <= SYNC_RST[1:0];
    end else begin
      sync_q[0] <= {lane_in, ss_in, sclk_in};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1][1:0];
    end
  end

  assign s_now    = sync_q[SYNC_STAGES-1];
  assign lane_s   = s_now[SW-1:2];
  assign rise     = s_now[0] & ~hist_q[0];
  assign fall     = ~s_now[0] & hist_q[0];
  assign smp_edge = SMP_RISE ? rise : fall;
  assign shf_edge = SMP_RISE ? fall : rise;
  assign ss_act   = s_now[1] == SS_ACTIVE;
  assign ss_act_h = hist_q[1] == SS_ACTIVE;
  assign ss_on    = ss_act & ~ss_act_h;
  assign ss_off   = ~ss_act & ss_act_h;

  state_t               state_q, state_d;
  logic [DSW-1:0]       cnt_q, cnt_d;
  logic [DSW-1:0]       n_q, n_d, n_clamp;
  logic [LANES-1:0]     sel_q, sel_d;
  logic [SEG_CNT_W-1:0] seg_q, seg_d, seg_inc;
  logic                 abort_q, abort_d;
  logic                 in_txn;
  logic latch, load, smp, shf, commit;

  assign n_clamp = (data_size > DSW'(MAX_DATA_SIZE)) ?
                   DSW'(MAX_DATA_SIZE) : data_size;
  assign seg_inc = (&seg_q) ? seg_q : seg_q + SEG_CNT_W'(1);
  assign in_txn  = state_q inside
    {ST_START, ST_EVAL_REQ, ST_EVAL, ST_LOAD, ST_SEG};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    abort_d = 1'b0;
    latch   = 1'b0;
    load    = 1'b0;
    smp     = 1'b0;
    shf     = 1'b0;
    commit  = 1'b0;
    // losing SS wins over any handshake or final edge
    if (in_txn && ss_off) begin
      abort_d = 1'b1;
      sel_d   = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ss_on) begin
          seg_d   = '0;
          state_d = ST_START;
        end
        ST_START:    state_d = ST_EVAL_REQ;
        ST_EVAL_REQ: state_d = ST_EVAL;
        ST_EVAL: if (eval_done) begin
          if (mitm_done) begin
            sel_d   = '0;
            state_d = ST_DONE;
          end else begin
            n_d     = n_clamp;
            sel_d   = fake_select;
            latch   = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          load  = 1'b1;
          cnt_d = '0;
          if (n_q == '0) begin
            seg_d   = seg_inc;
            state_d = ST_EVAL_REQ;
          end else begin
            state_d = ST_SEG;
          end
        end
        ST_SEG: begin
          shf = shf_edge;
          if (smp_edge) begin
            smp   = 1'b1;
            cnt_d = cnt_q + DSW'(1);
            if (cnt_d == n_q) begin
              commit  = 1'b1;
              seg_d   = seg_inc;
              state_d = ST_EVAL_REQ;
            end
          end
        end
        ST_DONE: if (ss_off) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      sel_q   <= '0;
      seg_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      abort_q <= abort_d;
    end
  end

  logic [LANES-1:0] fake_bit;
  logic             drive;

  assign drive = !CPHA && (n_q != '0);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_shifter #(
      .MAX (MAX_DATA_SIZE),
      .DSW (DSW)
    ) u_sh (
      .clk        (sys_clk),
      .rst_n      (rst),
      .latch_i    (latch),
      .fake_i     (fake_data[l*MAX_DATA_SIZE +: MAX_DATA_SIZE]),
      .load_i     (load),
      .drive_i    (drive),
      .sample_i   (smp),
      .commit_i   (commit),
      .shift_i    (shf),
      .bit_i      (lane_s[l]),
      .n_i        (n_q),
      .fake_bit_o (fake_bit[l]),
      .real_o     (real_data[l*MAX_DATA_SIZE +: MAX_DATA_SIZE])
    );
    assign lane_out[l] = (busy && sel_q[l]) ? fake_bit[l] : lane_in[l];
  end

  assign sclk_out   = sclk_in;
  assign ss_out     = ss_in;
  assign busy       = state_q != ST_IDLE;
  assign mitm_start = state_q == ST_START;
  assign mitm_eval  = state_q == ST_EVAL_REQ;
  assign seg_count  = seg_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_mitm_control_multi.sv
// Directed bench: mode 0 instance (u0) and mode 3 instance (u3)
// driven as SPI master/slave plus MITM logic responder.
module tb_mitm_control_multi;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        sclk [2];
  logic        ss   [2];
  logic [1:0]  lin  [2];
  logic        sco  [2];
  logic        sso  [2];
  logic [1:0]  lout [2];
  logic        mst  [2];
  logic        mev  [2];
  logic        edone[2];
  logic        mdone[2];
  logic [3:0]  dsz  [2];
  logic [17:0] fdat [2];
  logic [1:0]  fsel [2];
  logic [17:0] rdat [2];
  logic [7:0]  segc [2];
  logic        bsy  [2];
  logic        abrt [2];

  int checks = 0;
  int passed = 0;
  int ev_cnt[2] = '{0, 0};
  int st_cnt[2] = '{0, 0};
  int ev_ack[2] = '{0, 0};

  always #5 clk = ~clk;

  mitm_control_multi u0 (
    .sys_clk(clk), .rst(rst_n),
    .sclk_in(sclk[0]), .ss_in(ss[0]), .lane_in(lin[0]),
    .sclk_out(sco[0]), .ss_out(sso[0]), .lane_out(lout[0]),
    .mitm_start(mst[0]), .mitm_eval(mev[0]),
    .eval_done(edone[0]), .mitm_done(mdone[0]),
    .data_size(dsz[0]), .fake_data(fdat[0]),
    .fake_select(fsel[0]), .real_data(rdat[0]),
    .seg_count(segc[0]), .busy(bsy[0]), .abort(abrt[0])
  );

  mitm_control_multi #(.CPOL(1'b1), .CPHA(1'b1)) u3 (
    .sys_clk(clk), .rst(rst_n),
    .sclk_in(sclk[1]), .ss_in(ss[1]), .lane_in(lin[1]),
    .sclk_out(sco[1]), .ss_out(sso[1]), .lane_out(lout[1]),
    .mitm_start(mst[1]), .mitm_eval(mev[1]),
    .eval_done(edone[1]), .mitm_done(mdone[1]),
    .data_size(dsz[1]), .fake_data(fdat[1]),
    .fake_select(fsel[1]), .real_data(rdat[1]),
    .seg_count(segc[1]), .busy(bsy[1]), .abort(abrt[1])
  );

  always @(negedge clk) begin
    if (mev[0]) ev_cnt[0] <= ev_cnt[0] + 1;
    if (mev[1]) ev_cnt[1] <= ev_cnt[1] + 1;
    if (mst[0]) st_cnt[0] <= st_cnt[0] + 1;
    if (mst[1]) st_cnt[1] <= st_cnt[1] + 1;
  end

  task automatic eval(input int d, input logic done,
                      input logic [3:0] ds, input logic [17:0] fk,
                      input logic [1:0] sl);
    int t;
    t = 0;
    while (ev_cnt[d] == ev_ack[d] && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ev_cnt[d] == ev_ack[d]) begin
      $display("FAIL eval_wait[%0d]: got no mitm_eval, need 1", d);
      return;
    end
    passed++;
    ev_ack[d]++;
    @(negedge clk);
    edone[d] = 1'b1;
    mdone[d] = done;
    dsz[d]   = ds;
    fdat[d]  = fk;
    fsel[d]  = sl;
    @(negedge clk);
    edone[d] = 1'b0;
    mdone[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(input int d, input int n, input int nclk,
                      input logic [8:0] mosi, input logic [8:0] miso,
                      input logic [17:0] fk, input logic [1:0] sl);
    logic [8:0] o0, o1, e0, e1;
    o0 = '0; o1 = '0; e0 = '0; e1 = '0;
    for (int i = n - 1; i >= n - nclk; i--) begin
      if (d == 1) sclk[d] = 1'b0;
      lin[d] = {mosi[i], miso[i]};
      repeat (HALF) @(negedge clk);
      o0[i] = lout[d][0];
      o1[i] = lout[d][1];
      sclk[d] = 1'b1;
      repeat (HALF) @(negedge clk);
      if (d == 0) sclk[d] = 1'b0;
    end
    if (nclk == n) begin
      for (int i = 0; i < n; i++) begin
        e0[i] = sl[0] ? fk[i] : miso[i];
        e1[i] = sl[1] ? fk[9+i] : mosi[i];
      end
      checks++;
      if ({o1, o0} !== {e1, e0})
        $display("FAIL stream[%0d]: got %h want %h", d,
                 {o1, o0}, {e1, e0});
      else passed++;
    end
  endtask

  task automatic ss_off_wait(input int d);
    ss[d] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bsy[d] !== 1'b0)
      $display("FAIL idle_after_ss[%0d]: got busy=%b want 0", d, bsy[d]);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mst[0], mev[0], abrt[0], bsy[0]} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
               {mst[0], mev[0], abrt[0], bsy[0]});
    else passed++;
    checks++;
    if ({rdat[0], segc[0]} !== 26'h0)
      $display("FAIL reset_data: got %h/%h want 0/0", rdat[0], segc[0]);
    else passed++;
    checks++;
    if (lout[0] !== 2'b10 || sco[0] !== 1'b0 || sso[0] !== 1'b0)
      $display("FAIL reset_pass: got %b%b%b want 1000",
               lout[0], sco[0], sso[0]);
    else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode0_basic;
    int s0;
    s0 = st_cnt[0];
    ev_ack[0] = ev_cnt[0];
    ss[0] = 1'b1;
    eval(0, 1'b0, 4'd8, {9'h0, 9'h0A5}, 2'b01);
    checks++;
    if (st_cnt[0] - s0 !== 1)
      $display("FAIL start_pulse: got %0d want 1", st_cnt[0] - s0);
    else passed++;
    xfer(0, 8, 8, 9'h03C, 9'h0FF, {9'h0, 9'h0A5}, 2'b01);
    checks++;
    if (rdat[0] !== {9'h03C, 9'h0FF} || segc[0] !== 8'd1)
      $display("FAIL basic_real: got %h/%0d want %h/1",
               rdat[0], segc[0], {9'h03C, 9'h0FF});
    else passed++;
    eval(0, 1'b1, 4'd0, 18'h0, 2'b00);
    lin[0] = 2'b01;
    @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b1 || lout[0] !== 2'b01)
      $display("FAIL done_pass: got %b/%b want 1/01", bsy[0], lout[0]);
    else passed++;
    ss_off_wait(0);
  endtask

  task automatic test_two_segments;
    int e0;
    ev_ack[0] = ev_cnt[0];
    e0 = ev_cnt[0];
    ss[0] = 1'b1;
    eval(0, 1'b0, 4'd8, {9'h0, 9'h05A}, 2'b01);
    xfer(0, 8, 8, 9'h0C3, 9'h012, {9'h0, 9'h05A}, 2'b01);
    eval(0, 1'b0, 4'd4, {9'h006, 9'h0}, 2'b10);
    xfer(0, 4, 4, 9'h00B, 9'h005, {9'h006, 9'h0}, 2'b10);
    checks++;
    if (rdat[0] !== {9'h00B, 9'h005})
      $display("FAIL seg2_real: got %h want %h", rdat[0], {9'h00B, 9'h005});
    else passed++;
    eval(0, 1'b1, 4'd0, 18'h0, 2'b00);
    checks++;
    if (ev_cnt[0] - e0 !== 3 || segc[0] !== 8'd2 || bsy[0] !== 1'b1)
      $display("FAIL two_seg: got evals=%0d segs=%0d busy=%b want 3/2/1",
               ev_cnt[0] - e0, segc[0], bsy[0]);
    else passed++;
    ss_off_wait(0);
  endtask

  task automatic test_mode3;
    ev_ack[1] = ev_cnt[1];
    ss[1] = 1'b1;
    eval(1, 1'b0, 4'd9, {9'h0, 9'h1B3}, 2'b01);
    xfer(1, 9, 9, 9'h0C5, 9'h13A, {9'h0, 9'h1B3}, 2'b01);
    checks++;
    if (rdat[1] !== {9'h0C5, 9'h13A} || segc[1] !== 8'd1)
      $display("FAIL mode3_real: got %h/%0d want %h/1",
               rdat[1], segc[1], {9'h0C5, 9'h13A});
    else passed++;
    eval(1, 1'b1, 4'd0, 18'h0, 2'b00);
    ss_off_wait(1);
  endtask

  task automatic test_abort;
    int t;
    ev_ack[0] = ev_cnt[0];
    ss[0] = 1'b1;
    eval(0, 1'b0, 4'd8, {9'h0, 9'h0A5}, 2'b01);
    xfer(0, 8, 3, 9'h03C, 9'h0FF, {9'h0, 9'h0A5}, 2'b01);
    lin[0] = 2'b11;
    ss[0] = 1'b0;
    t = 0;
    while (!abrt[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (abrt[0] !== 1'b1)
      $display("FAIL abort_pulse: got %b want 1", abrt[0]);
    else passed++;
    checks++;
    if (bsy[0] !== 1'b0 || lout[0] !== 2'b11 || segc[0] !== 8'd0)
      $display("FAIL abort_state: got %b/%b/%0d want 0/11/0",
               bsy[0], lout[0], segc[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (abrt[0] !== 1'b0)
      $display("FAIL abort_width: got %b want 0", abrt[0]);
    else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_size_edges;
    ev_ack[0] = ev_cnt[0];
    ss[0] = 1'b1;
    eval(0, 1'b0, 4'd0, 18'h0, 2'b01);
    checks++;
    if (segc[0] !== 8'd1)
      $display("FAIL size0: got seg=%0d want 1", segc[0]);
    else passed++;
    eval(0, 1'b0, 4'd15, {9'h0, 9'h156}, 2'b01);
    xfer(0, 9, 9, 9'h1C3, 9'h0AA, {9'h0, 9'h156}, 2'b01);
    checks++;
    if (rdat[0] !== {9'h1C3, 9'h0AA} || segc[0] !== 8'd2)
      $display("FAIL size15: got %h/%0d want %h/2",
               rdat[0], segc[0], {9'h1C3, 9'h0AA});
    else passed++;
    eval(0, 1'b1, 4'd0, 18'h0, 2'b00);
    ss_off_wait(0);
  endtask

  task automatic test_async_reset;
    ev_ack[0] = ev_cnt[0];
    ss[0] = 1'b1;
    eval(0, 1'b0, 4'd4, {9'h0, 9'h005}, 2'b01);
    xfer(0, 4, 4, 9'h00A, 9'h003, {9'h0, 9'h005}, 2'b01);
    eval(0, 1'b0, 4'd8, {9'h0, 9'h0A5}, 2'b01);
    xfer(0, 8, 2, 9'h0FF, 9'h000, {9'h0, 9'h0A5}, 2'b01);
    lin[0] = 2'b11;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mst[0], mev[0], abrt[0], bsy[0]} !== 4'b0 || lout[0] !== 2'b11)
      $display("FAIL arst_flags: got %b/%b want 0000/11",
               {mst[0], mev[0], abrt[0], bsy[0]}, lout[0]);
    else passed++;
    checks++;
    if (rdat[0] !== 18'h0 || segc[0] !== 8'd0)
      $display("FAIL arst_data: got %h/%0d want 0/0", rdat[0], segc[0]);
    else passed++;
    ss[0] = 1'b0;
    sclk[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ev_ack[0] = ev_cnt[0];
    ss[0] = 1'b1;
    eval(0, 1'b0, 4'd4, {9'h0, 9'h009}, 2'b01);
    xfer(0, 4, 4, 9'h005, 9'h00C, {9'h0, 9'h009}, 2'b01);
    checks++;
    if (rdat[0] !== {9'h005, 9'h00C} || segc[0] !== 8'd1)
      $display("FAIL arst_restart: got %h/%0d want %h/1",
               rdat[0], segc[0], {9'h005, 9'h00C});
    else passed++;
    eval(0, 1'b1, 4'd0, 18'h0, 2'b00);
    ss_off_wait(0);
  endtask

  initial begin
    sclk[0] = 1'b0; sclk[1] = 1'b1;
    ss[0] = 1'b0;   ss[1] = 1'b0;
    lin[0] = 2'b10; lin[1] = 2'b00;
    for (int d = 0; d < 2; d++) begin
      edone[d] = 1'b0; mdone[d] = 1'b0;
      dsz[d] = '0; fdat[d] = '0; fsel[d] = '0;
    end
    test_reset;
    test_mode0_basic;
    test_two_segments;
    test_mode3;
    test_abort;
    test_size_edges;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
